// File: rtl/beta_shared_arbiter_pkg.sv
// Shared definitions for the Beta CPU / laser engine BRAM arbiter:
// FSM state encodings, grant identifiers and default bus widths.
package beta_shared_arbiter_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_ENG = 1'b1
  } grant_t;

endpackage

// File: rtl/beta_shared_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker. req[0] is the CPU, req[1] the engine;
// on a tie the requester that did not win last time is chosen.
module rr_arb2
  import beta_shared_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  grant_t     last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == GNT_ENG) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/beta_shared_arbiter.sv
// Shares one single-port, 1-cycle-latency BRAM between the Beta CPU and the laser
// scan engine. Fixed four-cycle access: IDLE -> ACCESS -> CAPTURE -> DONE.
module beta_shared_arbiter
  import beta_shared_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,

  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic [DATA_W-1:0] eng_rdata,
  output logic              eng_ack,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state, state_nxt;
  grant_t            winner, winner_nxt;
  grant_t            last_grant, last_grant_nxt;
  logic              acc_we, acc_we_nxt;
  logic [1:0]        grant;

  logic              mem_en_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic              cpu_ack_nxt, eng_ack_nxt;
  logic [DATA_W-1:0] cpu_rdata_nxt, eng_rdata_nxt;

  rr_arb2 u_rr_arb2 (
    .req        ({eng_req, cpu_req}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_nxt      = state;
    winner_nxt     = winner;
    last_grant_nxt = last_grant;
    acc_we_nxt     = acc_we;
    mem_en_nxt     = 1'b0;
    mem_we_nxt     = 1'b0;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    cpu_ack_nxt    = 1'b0;
    eng_ack_nxt    = 1'b0;
    cpu_rdata_nxt  = cpu_rdata;
    eng_rdata_nxt  = eng_rdata;

    case (state)
      IDLE: begin
        if (grant != 2'b00) begin
          winner_nxt     = grant[1] ? GNT_ENG : GNT_CPU;
          last_grant_nxt = grant[1] ? GNT_ENG : GNT_CPU;
          acc_we_nxt     = grant[1] ? eng_we : cpu_we;
          mem_en_nxt     = 1'b1;
          mem_we_nxt     = grant[1] ? eng_we : cpu_we;
          mem_addr_nxt   = grant[1] ? eng_addr : cpu_addr;
          mem_wdata_nxt  = grant[1] ? eng_wdata : cpu_wdata;
          state_nxt      = ACCESS;
        end
      end
      ACCESS: state_nxt = CAPTURE;
      CAPTURE: begin
        // BRAM read data is valid now, one cycle after the enable strobe.
        if (winner == GNT_CPU) begin
          cpu_ack_nxt = 1'b1;
          if (!acc_we) cpu_rdata_nxt = mem_rdata;
        end else begin
          eng_ack_nxt = 1'b1;
          if (!acc_we) eng_rdata_nxt = mem_rdata;
        end
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples the values
  // from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      winner     <= GNT_CPU;
      last_grant <= GNT_ENG;
      acc_we     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_ack    <= 1'b0;
      eng_ack    <= 1'b0;
      cpu_rdata  <= '0;
      eng_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      winner     <= winner_nxt;
      last_grant <= last_grant_nxt;
      acc_we     <= acc_we_nxt;
      mem_en     <= mem_en_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      cpu_ack    <= cpu_ack_nxt;
      eng_ack    <= eng_ack_nxt;
      cpu_rdata  <= cpu_rdata_nxt;
      eng_rdata  <= eng_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_beta_shared_arbiter.sv
// Self-checking bench for beta_shared_arbiter: behavioural BRAM, reference memory,
// per-port scoreboard queues of expected read data popped on each ack.
module tb_beta_shared_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, eng_req, eng_we;
  logic [AW-1:0] cpu_addr, eng_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, eng_wdata, cpu_rdata, eng_rdata;
  logic          cpu_ack, eng_ack, mem_en, mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  beta_shared_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .eng_req   (eng_req),
    .eng_we    (eng_we),
    .eng_addr  (eng_addr),
    .eng_wdata (eng_wdata),
    .eng_rdata (eng_rdata),
    .eng_ack   (eng_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural BRAM with a preload port used only while the DUT is idle.
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic [DW-1:0] bram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (pl_en) bram[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] exp_last [2];
  logic [DW-1:0] cpu_q [$];
  logic [DW-1:0] eng_q [$];
  int            ack_log [$];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  // Monitor: protocol checks on the memory side, scoreboard pops on acks.
  logic          prev_en = 1'b0;
  int            last_en_cyc = -1;
  logic          last_en_we;
  logic [AW-1:0] last_en_addr;
  logic [DW-1:0] last_en_wdata;
  int            cpu_ack_cyc = -1;
  int            eng_ack_cyc = -1;

  always @(negedge clk) begin
    if (reset) prev_en = 1'b0;
    else begin
      if (mem_we) check("mem_we_without_en", {31'd0, mem_en}, 32'd1);
      if (mem_en) begin
        check("mem_en_width", {31'd0, prev_en}, 32'd0);
        last_en_cyc   = cyc;
        last_en_we    = mem_we;
        last_en_addr  = mem_addr;
        last_en_wdata = mem_wdata;
      end
      prev_en = mem_en;
      if (cpu_ack) begin
        cpu_ack_cyc = cyc;
        ack_log.push_back(0);
        if (cpu_q.size() == 0) check("cpu_unexpected_ack", 32'd1, 32'd0);
        else check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end
      if (eng_ack) begin
        eng_ack_cyc = cyc;
        ack_log.push_back(1);
        if (eng_q.size() == 0) check("eng_unexpected_ack", 32'd1, 32'd0);
        else check("eng_rdata", eng_rdata, eng_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ref_mem[int'(a)] = d;
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick(1);
    pl_en   = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_last[0] = '0;
    exp_last[1] = '0;
  endtask

  // One request/ack handshake; called just after a rising edge. With keep set,
  // req stays high after the ack so the caller can present the next request.
  task automatic access(input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input bit keep,
                        output int start_cyc, output int ack_cyc);
    logic [DW-1:0] exp;
    bit            seen;
    if (we) begin
      ref_mem[int'(addr)] = wdata;
      exp = exp_last[port];
    end else begin
      exp = ref_rd(addr);
      exp_last[port] = exp;
    end
    if (port == 1'b0) begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
      cpu_q.push_back(exp);
    end else begin
      eng_we = we; eng_addr = addr; eng_wdata = wdata; eng_req = 1'b1;
      eng_q.push_back(exp);
    end
    start_cyc = cyc;
    ack_cyc   = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = (port == 1'b0) ? cpu_ack : eng_ack;
      if (seen) begin
        ack_cyc = cyc;
        break;
      end
    end
    if (ack_cyc < 0) begin
      if (port == 1'b0) check("cpu_ack_timeout", 32'd0, 32'd1);
      else check("eng_ack_timeout", 32'd0, 32'd1);
    end
    tick(1);
    if (!keep) begin
      if (port == 1'b0) cpu_req = 1'b0;
      else eng_req = 1'b0;
    end
  endtask

  int s0, a0, s1, a1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    eng_req = 1'b0; eng_we = 1'b0; eng_addr = '0; eng_wdata = '0;
    exp_last[0] = '0;
    exp_last[1] = '0;
    tick(1);
    preload(14'h0010, 32'hDEADBEEF);
    preload(14'h0020, 32'hCAFEF00D);
    preload(14'h0100, 32'h00000000);
    preload(14'h0200, 32'h11110000);
    preload(14'h0201, 32'h22220000);
    for (int i = 0; i < 4; i++) begin
      preload(14'h0210 + 14'(i), 32'h3000_0000 + 32'(i));
      preload(14'h0220 + 14'(i), 32'h4000_0000 + 32'(i));
    end

    check("rst_mem_en",    {31'd0, mem_en},  32'd0);
    check("rst_mem_we",    {31'd0, mem_we},  32'd0);
    check("rst_mem_addr",  {18'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_acks",      {30'd0, cpu_ack, eng_ack}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_eng_rdata", eng_rdata, 32'd0);
    reset = 1'b0;

    // Reset asserted during ACCESS of a CPU read aborts it without an ack.
    cpu_we = 1'b0; cpu_addr = 14'h0010; cpu_req = 1'b1;
    tick(1);
    @(negedge clk);
    check("t1_access_en", {31'd0, mem_en}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t1_rst_mem_en",   {31'd0, mem_en},  32'd0);
    check("t1_rst_mem_addr", {18'd0, mem_addr}, 32'd0);
    check("t1_rst_acks",     {30'd0, cpu_ack, eng_ack}, 32'd0);
    check("t1_rst_rdata",    cpu_rdata | eng_rdata, 32'd0);
    cpu_req = 1'b0;
    cpu_ack_cyc = -1;
    tick(1);
    reset = 1'b0;
    tick(6);
    check("t1_no_ack", 32'(cpu_ack_cyc), 32'hFFFF_FFFF);

    // CPU-only read.
    access(1'b0, 1'b0, 14'h0010, '0, 1'b0, s0, a0);
    check("t2_en_cyc",  32'(last_en_cyc), 32'(s0 + 1));
    check("t2_en_addr", {18'd0, last_en_addr}, 32'h0010);
    check("t2_ack_cyc", 32'(a0), 32'(s0 + 3));
    tick(2);

    // Engine read to give eng_rdata a value, then engine write at the top address.
    access(1'b1, 1'b0, 14'h0010, '0, 1'b0, s1, a1);
    access(1'b1, 1'b1, 14'h3FFF, 32'h12345678, 1'b0, s1, a1);
    check("t3_en_cyc",   32'(last_en_cyc), 32'(s1 + 1));
    check("t3_we",       {31'd0, last_en_we}, 32'd1);
    check("t3_addr",     {18'd0, last_en_addr}, 32'h3FFF);
    check("t3_wdata",    last_en_wdata, 32'h12345678);
    check("t3_ack_cyc",  32'(a1), 32'(s1 + 3));
    check("t3_rdata_kept", eng_rdata, 32'hDEADBEEF);
    tick(1);

    // Engine request raised while the CPU access is in ACCESS.
    fork
      access(1'b0, 1'b0, 14'h0010, '0, 1'b0, s0, a0);
      begin
        tick(1);
        access(1'b1, 1'b0, 14'h0020, '0, 1'b0, s1, a1);
      end
    join
    check("t5_cpu_ack", 32'(a0), 32'(s0 + 3));
    check("t5_eng_ack", 32'(a1), 32'(s0 + 7));
    check("t5_eng_en",  32'(last_en_cyc), 32'(s0 + 5));
    tick(2);

    // CPU write followed by engine read of the same word.
    access(1'b0, 1'b1, 14'h0100, 32'hA5A5A5A5, 1'b0, s0, a0);
    access(1'b1, 1'b0, 14'h0100, '0, 1'b0, s1, a1);
    check("t6_eng_rdata", eng_rdata, 32'hA5A5A5A5);
    check("t6_cpu_kept",  cpu_rdata, exp_last[0]);

    // Simultaneous requests right after reset: CPU first.
    pulse_reset();
    fork
      access(1'b0, 1'b0, 14'h0200, '0, 1'b0, s0, a0);
      access(1'b1, 1'b0, 14'h0201, '0, 1'b0, s1, a1);
    join
    check("t4_cpu_ack", 32'(a0), 32'(s0 + 3));
    check("t4_eng_ack", 32'(a1), 32'(s0 + 7));
    tick(1);

    // Both requesters continuously re-requesting: strict alternation.
    ack_log.delete();
    fork
      for (int i = 0; i < 4; i++)
        access(1'b0, 1'b0, 14'h0210 + 14'(i), '0, (i < 3), s0, a0);
      for (int j = 0; j < 4; j++)
        access(1'b1, 1'b0, 14'h0220 + 14'(j), '0, (j < 3), s1, a1);
    join
    check("t4_ack_count", 32'(ack_log.size()), 32'd8);
    for (int i = 0; i < ack_log.size(); i++)
      check($sformatf("t4_order_%0d", i), 32'(ack_log[i]), 32'(i % 2));
    tick(4);

    check("sb_cpu_empty", 32'(cpu_q.size()), 32'd0);
    check("sb_eng_empty", 32'(eng_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
